// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers and FSM encoding.
// Inverse-column helpers exist only when MIX_COLUMNS_INV_EN is defined.
package aes_pkg;

  typedef logic [0:127] state_t;
  typedef logic [0:31]  col_t;
  typedef logic [7:0]   byte_t;

  localparam byte_t AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gmul2(input byte_t b);
    return xtime(b);
  endfunction

  function automatic byte_t gmul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  // Products by 9/b/d/e built from x^1, x^2, x^3 partials.
  function automatic byte_t gmul9(input byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic byte_t gmul0b(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic byte_t gmul0d(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic byte_t gmul0e(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction
`endif

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column (byte 0 = MSB = row 0).
// With MIX_COLUMNS_INV_EN defined, inv_i selects InvMixColumns.
module mix_single_column
  import aes_pkg::*;
(
  input  col_t col_i,
`ifdef MIX_COLUMNS_INV_EN
  input  logic inv_i,
`endif
  output col_t col_o
);

  byte_t a [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      byte_t fwd;
      assign a[gi] = col_i[8*gi +: 8];
      // Row gi sees the circulant coefficient row rotated by gi.
      assign fwd = gmul2(a[gi]) ^ gmul3(a[(gi+1)%4]) ^ a[(gi+2)%4] ^ a[(gi+3)%4];
`ifdef MIX_COLUMNS_INV_EN
      byte_t inv;
      assign inv = gmul0e(a[gi]) ^ gmul0b(a[(gi+1)%4]) ^
                   gmul0d(a[(gi+2)%4]) ^ gmul9(a[(gi+3)%4]);
      assign col_o[8*gi +: 8] = inv_i ? inv : fwd;
`else
      assign col_o[8*gi +: 8] = fwd;
`endif
    end
  endgenerate

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one column per clock through a shared column mixer.
// Define MIX_COLUMNS_INV_EN to add the in_inv port and InvMixColumns support.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int NCOL = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  state_t in_state,
  input  logic   in_last,
`ifdef MIX_COLUMNS_INV_EN
  input  logic   in_inv,
`endif
  input  logic   in_valid,
  output logic   in_ready,
  output state_t out_state,
  output logic   out_valid,
  input  logic   out_ready
);

  localparam int            CW       = $clog2(NCOL);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCOL - 1);

  fsm_t          state_q;
  logic [CW-1:0] cnt_q;
  state_t        data_q;
  state_t        data_d;
  logic          last_q;
  logic          in_ready_q;
  logic          out_valid_q;
  col_t          cols [NCOL];
  col_t          col_sel;
  col_t          col_mixed;
`ifdef MIX_COLUMNS_INV_EN
  logic          inv_q;
`endif

  generate
    for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
      assign cols[gi] = data_q[32*gi +: 32];
    end
  endgenerate

  assign col_sel = cols[cnt_q];

  mix_single_column u_mix (
    .col_i (col_sel),
`ifdef MIX_COLUMNS_INV_EN
    .inv_i (inv_q),
`endif
    .col_o (col_mixed)
  );

  always_comb begin
    data_d = data_q;
    data_d[32*cnt_q +: 32] = col_mixed;
  end

  // in_ready_q stays low for the first IDLE cycle after reset, so nothing is accepted then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_ready_q && in_valid) begin
            data_q     <= in_state;
            last_q     <= in_last;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_BUSY;
`ifdef MIX_COLUMNS_INV_EN
            inv_q      <= in_inv;
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (last_q) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            data_q <= data_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q       <= '0;
              out_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_state = data_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter: FIPS-197 vectors, handshake corners,
// and randomized states checked against a generic GF(2^8) matrix model.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:127] in_state;
  logic         in_last;
  logic         in_inv;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] out_state;
  logic         out_valid;
  logic         out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mix_columns_iter #(.NCOL(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_state  (in_state),
    .in_last   (in_last),
`ifdef MIX_COLUMNS_INV_EN
    .in_inv    (in_inv),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_state (out_state),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    string        name;
    logic [0:127] st;
    bit           last;
    bit           inv;
    logic [0:127] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain shift-and-add multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Each column times the circulant matrix whose first row is base[].
  function automatic logic [0:127] ref_model(input logic [0:127] s, input bit last, input bit inv);
    logic [7:0]   base [4];
    logic [0:127] r;
    logic [7:0]   acc;
    if (last) return s;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gf_mul(base[(k - row + 4) % 4], s[32*c + 8*k +: 8]);
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic run_txn(input string name, input logic [0:127] st, input bit last, input bit inv,
                         input logic [0:127] exp, input int exp_lat, input bit hold_valid,
                         input int bp_cycles);
    int w = 0;
    int lat = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({name, " ready_wait"}, 128'(in_ready), 128'(1));
    in_state = st;
    in_last  = last;
    in_inv   = inv;
    in_valid = 1'b1;
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_last  = ~last;
    chk({name, " busy_in_ready"}, 128'(in_ready), 128'(0));
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, 128'(lat), 128'(exp_lat));
    chk({name, " out_state"}, out_state, exp);
    in_valid = 1'b0;
    for (int i = 0; i < bp_cycles; i++) begin
      @(negedge clk);
      chk({name, " bp_state"}, out_state, exp);
      chk({name, " bp_in_ready"}, 128'(in_ready), 128'(0));
      chk({name, " bp_out_valid"}, 128'(out_valid), 128'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, " release_in_ready"}, 128'(in_ready), 128'(1));
    chk({name, " release_out_valid"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         v;
    logic [0:127] rs;
    bit           rl;
    bit           ri;

    rst_n = 1'b0; in_state = '0; in_last = 1'b0; in_inv = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;

    v.name = "fips_col0";  v.st = 128'hdb135345_00000000_00000000_00000000; v.last = 1'b0; v.inv = 1'b0;
    v.exp  = 128'h8e4da1bc_00000000_00000000_00000000; v.lat = 4; vecs.push_back(v);
    v.name = "fips_round1"; v.st = 128'hd4bf5d30e0b452aeb84111f11e2798e5; v.last = 1'b0; v.inv = 1'b0;
    v.exp  = 128'h046681e5e0cb199a48f8d37a2806264c; v.lat = 4; vecs.push_back(v);
    v.name = "bypass";     v.st = 128'hd4bf5d30e0b452aeb84111f11e2798e5; v.last = 1'b1; v.inv = 1'b0;
    v.exp  = 128'hd4bf5d30e0b452aeb84111f11e2798e5; v.lat = 1; vecs.push_back(v);
    v.name = "all_ones";   v.st = {4{32'h01010101}}; v.last = 1'b0; v.inv = 1'b0;
    v.exp  = {4{32'h01010101}}; v.lat = 4; vecs.push_back(v);
`ifdef MIX_COLUMNS_INV_EN
    v.name = "inv_round1"; v.st = 128'h046681e5e0cb199a48f8d37a2806264c; v.last = 1'b0; v.inv = 1'b1;
    v.exp  = 128'hd4bf5d30e0b452aeb84111f11e2798e5; v.lat = 4; vecs.push_back(v);
    v.name = "inv_bypass"; v.st = 128'h046681e5e0cb199a48f8d37a2806264c; v.last = 1'b1; v.inv = 1'b1;
    v.exp  = 128'h046681e5e0cb199a48f8d37a2806264c; v.lat = 1; vecs.push_back(v);
`endif

    repeat (2) @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_state", out_state, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", 128'(in_ready), 128'(1));

    foreach (vecs[i])
      run_txn(vecs[i].name, vecs[i].st, vecs[i].last, vecs[i].inv, vecs[i].exp, vecs[i].lat, 1'b0, 0);

    // Backpressure in DONE, with in_valid held high through BUSY and DONE.
    run_txn("backpressure", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0,
            128'h046681e5e0cb199a48f8d37a2806264c, 4, 1'b1, 10);

    // Reset after the second column edge.
    in_state = 128'hd4bf5d30e0b452aeb84111f11e2798e5; in_last = 1'b0; in_inv = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_out_valid", 128'(out_valid), 128'(0));
    chk("midreset_in_ready", 128'(in_ready), 128'(0));
    chk("midreset_out_state", out_state, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_recover_in_ready", 128'(in_ready), 128'(1));
    chk("midreset_recover_out_valid", 128'(out_valid), 128'(0));
    run_txn("after_midreset", 128'hdb135345_00000000_00000000_00000000, 1'b0, 1'b0,
            128'h8e4da1bc_00000000_00000000_00000000, 4, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rl = ($urandom_range(0, 3) == 0);
`ifdef MIX_COLUMNS_INV_EN
      ri = $urandom_range(0, 1) == 1;
`else
      ri = 1'b0;
`endif
      run_txn($sformatf("random%0d", i), rs, rl, ri, ref_model(rs, rl, ri), rl ? 1 : 4,
              1'b0, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
